// File: rtl/id_pipe_if.sv
// id_pipe_if: handshake and decoded-field bundle between fetch, id_pipe and execute.
// master: upstream/downstream side (drives instruction, flush and out_ready_i).
// slave: id_pipe itself (drives in_ready_o and every decoded field).
interface id_pipe_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    // upstream side
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [ADDR_W-1:0] in_pc_i;
    logic [31:0]       in_inst_i;
    // downstream side
    logic              out_valid_o;
    logic              out_ready_i;
    logic [ADDR_W-1:0] out_pc_o;
    logic [6:0]        out_opcode_o;
    logic [4:0]        out_rd_o;
    logic [4:0]        out_rs1_o;
    logic [4:0]        out_rs2_o;
    logic [2:0]        out_funct3_o;
    logic [6:0]        out_funct7_o;
    logic [XLEN-1:0]   out_imm_o;
    logic [11:0]       out_csr_addr_o;
    logic              out_rd_we_o;
    logic              out_rs1_re_o;
    logic              out_rs2_re_o;
    logic              out_err_o;

    modport master (
        output flush_i, in_valid_i, in_pc_i, in_inst_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_pc_o, out_opcode_o, out_rd_o,
               out_rs1_o, out_rs2_o, out_funct3_o, out_funct7_o, out_imm_o,
               out_csr_addr_o, out_rd_we_o, out_rs1_re_o, out_rs2_re_o, out_err_o
    );

    modport slave (
        input  flush_i, in_valid_i, in_pc_i, in_inst_i, out_ready_i,
        output in_ready_o, out_valid_o, out_pc_o, out_opcode_o, out_rd_o,
               out_rs1_o, out_rs2_o, out_funct3_o, out_funct7_o, out_imm_o,
               out_csr_addr_o, out_rd_we_o, out_rs1_re_o, out_rs2_re_o, out_err_o
    );
endinterface

// File: rtl/id_pipe.sv
// id_pipe: RV32/RV64 instruction decode stage with 2-entry skid buffer and illegal-instruction detection.
// Latency: 1 cycle from input transfer to out_valid_o when empty; strict FIFO order.
// Backpressure: in_ready_o is registered (low only when both entries are full); flush_i empties the stage.
// Ports: clk, rst (async active-high), bus (id_pipe_if.slave: in_* request side, out_* decoded side).
module id_pipe #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    id_pipe_if.slave    bus
);
    localparam logic [6:0] OPC_LUI     = 7'h37;
    localparam logic [6:0] OPC_AUIPC   = 7'h17;
    localparam logic [6:0] OPC_JAL     = 7'h6F;
    localparam logic [6:0] OPC_JALR    = 7'h67;
    localparam logic [6:0] OPC_BRANCH  = 7'h63;
    localparam logic [6:0] OPC_LOAD    = 7'h03;
    localparam logic [6:0] OPC_STORE   = 7'h23;
    localparam logic [6:0] OPC_OPIMM   = 7'h13;
    localparam logic [6:0] OPC_OP      = 7'h33;
    localparam logic [6:0] OPC_OPIMM32 = 7'h1B;
    localparam logic [6:0] OPC_OP32    = 7'h3B;
    localparam logic [6:0] OPC_SYSTEM  = 7'h73;

    localparam int         SH_W      = (XLEN == 64) ? 6 : 5;
    localparam logic [2:0] STORE_MAX = (XLEN == 64) ? 3'd3 : 3'd2;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [6:0]        opcode;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [XLEN-1:0]   imm;
        logic [11:0]       csr;
        logic              rd_we;
        logic              rs1_re;
        logic              rs2_re;
        logic              err;
    } dec_t;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    // ------------------------------------------------------------------
    // Combinational decode of the offered word
    // ------------------------------------------------------------------
    logic [31:0]     inst;
    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [6:0]      shift_up;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_sh5, imm_z;
    logic            legal;
    dec_t            f;
    dec_t            dec;

    assign inst   = bus.in_inst_i;
    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    // At RV64 inst[25] is shamt[5]; mask it so the shift qualifier compares
    // against funct7-style values (0x00 / 0x20) at both widths.
    assign shift_up = (XLEN == 64) ? {inst[31:26], 1'b0} : inst[31:25];

    assign imm_i   = XLEN'($signed(inst[31:20]));
    assign imm_s   = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b   = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u   = XLEN'($signed({inst[31:12], 12'h000}));
    assign imm_j   = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    assign imm_sh  = XLEN'(inst[20 +: SH_W]);
    assign imm_sh5 = XLEN'(inst[24:20]);
    assign imm_z   = XLEN'(inst[19:15]);

    always_comb begin
        f     = '0;
        legal = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                legal = 1'b1;
                f.rd = rd; f.imm = imm_u; f.rd_we = 1'b1;
            end
            OPC_JAL: begin
                legal = 1'b1;
                f.rd = rd; f.imm = imm_j; f.rd_we = 1'b1;
            end
            OPC_JALR: begin
                legal = (funct3 == 3'd0);
                f.rd = rd; f.rs1 = rs1; f.funct3 = funct3; f.imm = imm_i;
                f.rd_we = 1'b1; f.rs1_re = 1'b1;
            end
            OPC_BRANCH: begin
                legal = (funct3 != 3'd2) && (funct3 != 3'd3);
                f.rs1 = rs1; f.rs2 = rs2; f.funct3 = funct3; f.imm = imm_b;
                f.rs1_re = 1'b1; f.rs2_re = 1'b1;
            end
            OPC_LOAD: begin
                legal = (funct3 != 3'd7) &&
                        !((XLEN == 32) && ((funct3 == 3'd3) || (funct3 == 3'd6)));
                f.rd = rd; f.rs1 = rs1; f.funct3 = funct3; f.imm = imm_i;
                f.rd_we = 1'b1; f.rs1_re = 1'b1;
            end
            OPC_STORE: begin
                legal = (funct3 <= STORE_MAX);
                f.rs1 = rs1; f.rs2 = rs2; f.funct3 = funct3; f.imm = imm_s;
                f.rs1_re = 1'b1; f.rs2_re = 1'b1;
            end
            OPC_OPIMM: begin
                f.rd = rd; f.rs1 = rs1; f.funct3 = funct3;
                f.rd_we = 1'b1; f.rs1_re = 1'b1;
                if ((funct3 == 3'd1) || (funct3 == 3'd5)) begin
                    // SLLI needs zero upper bits; SRLI/SRAI also accept 0x20
                    legal    = (shift_up == 7'h00) || ((funct3 == 3'd5) && (shift_up == 7'h20));
                    f.funct7 = shift_up;
                    f.imm    = imm_sh;
                end else begin
                    legal = 1'b1;
                    f.imm = imm_i;
                end
            end
            OPC_OP: begin
                legal = (funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))) ||
                        ((funct7 == 7'h01) && ENABLE_M);
                f.rd = rd; f.rs1 = rs1; f.rs2 = rs2; f.funct3 = funct3; f.funct7 = funct7;
                f.rd_we = 1'b1; f.rs1_re = 1'b1; f.rs2_re = 1'b1;
            end
            OPC_OPIMM32: begin
                legal = (XLEN == 64);
                f.rd = rd; f.rs1 = rs1; f.funct3 = funct3;
                f.rd_we = 1'b1; f.rs1_re = 1'b1;
                // word shifts always carry a 5-bit shamt
                if ((funct3 == 3'd1) || (funct3 == 3'd5)) begin
                    f.funct7 = funct7;
                    f.imm    = imm_sh5;
                end else begin
                    f.imm = imm_i;
                end
            end
            OPC_OP32: begin
                legal = (XLEN == 64);
                f.rd = rd; f.rs1 = rs1; f.rs2 = rs2; f.funct3 = funct3; f.funct7 = funct7;
                f.rd_we = 1'b1; f.rs1_re = 1'b1; f.rs2_re = 1'b1;
            end
            OPC_SYSTEM: begin
                if (funct3 == 3'd0) begin
                    // only ECALL / EBREAK / MRET; they carry no operands
                    legal = (inst == 32'h0000_0073) || (inst == 32'h0010_0073) ||
                            (inst == 32'h3020_0073);
                end else if (funct3 != 3'd4) begin
                    legal = 1'b1;
                    f.rd = rd; f.funct3 = funct3; f.csr = inst[31:20]; f.rd_we = 1'b1;
                    if (funct3[2]) begin
                        f.imm = imm_z;          // CSR*I: rs1 field is a zimm
                    end else begin
                        f.rs1 = rs1; f.rs1_re = 1'b1;
                    end
                end
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        dec        = '0;
        dec.pc     = bus.in_pc_i;
        dec.opcode = opcode;
        if (legal) begin
            dec        = f;
            dec.pc     = bus.in_pc_i;
            dec.opcode = opcode;
            dec.rd_we  = f.rd_we && (f.rd != 5'd0);
        end else begin
            dec.err = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output register + skid entry, single FSM with registered controls
    // ------------------------------------------------------------------
    state_t state;
    dec_t   out_q, skid_q;
    logic   out_vld_q, in_rdy_q;
    logic   in_xfer, out_xfer;

    assign in_xfer  = bus.in_valid_i & in_rdy_q;
    assign out_xfer = out_vld_q & bus.out_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_EMPTY;
            out_q     <= '0;
            skid_q    <= '0;
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
        end else if (bus.flush_i) begin
            state     <= S_EMPTY;
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_xfer) begin
                        out_q     <= dec;
                        out_vld_q <= 1'b1;
                        state     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_xfer && out_xfer) begin
                        out_q <= dec;
                    end else if (in_xfer) begin
                        skid_q   <= dec;
                        in_rdy_q <= 1'b0;
                        state    <= S_TWO;
                    end else if (out_xfer) begin
                        out_vld_q <= 1'b0;
                        state     <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (out_xfer) begin
                        out_q    <= skid_q;
                        in_rdy_q <= 1'b1;
                        state    <= S_ONE;
                    end
                end
                default: begin
                    state     <= S_EMPTY;
                    out_vld_q <= 1'b0;
                    in_rdy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready_o     = in_rdy_q;
    assign bus.out_valid_o    = out_vld_q;
    assign bus.out_pc_o       = out_q.pc;
    assign bus.out_opcode_o   = out_q.opcode;
    assign bus.out_rd_o       = out_q.rd;
    assign bus.out_rs1_o      = out_q.rs1;
    assign bus.out_rs2_o      = out_q.rs2;
    assign bus.out_funct3_o   = out_q.funct3;
    assign bus.out_funct7_o   = out_q.funct7;
    assign bus.out_imm_o      = out_q.imm;
    assign bus.out_csr_addr_o = out_q.csr;
    assign bus.out_rd_we_o    = out_q.rd_we;
    assign bus.out_rs1_re_o   = out_q.rs1_re;
    assign bus.out_rs2_re_o   = out_q.rs2_re;
    assign bus.out_err_o      = out_q.err;
endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: drives an RV32 (M enabled) and an RV64 (M disabled) id_pipe with identical stimulus.
// Expected decodes come from a reference decoder written from the ISA rules.
// Directed scenarios first, then a randomized stream with random backpressure and flushes.
module tb_id_pipe;
    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic [11:0] csr;
        logic        we;
        logic        re1;
        logic        re2;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, in_vld = 1'b0, out_rdy = 1'b0;
    logic [31:0] pc_d = '0, inst_d = '0;
    int          errors = 0, checks = 0;
    exp_t        q32[$], q64[$];

    always #5 clk = ~clk;

    id_pipe_if #(.XLEN(32), .ADDR_W(32)) b32 ();
    id_pipe_if #(.XLEN(64), .ADDR_W(32)) b64 ();

    assign b32.flush_i = flush;  assign b32.in_valid_i = in_vld;  assign b32.in_pc_i = pc_d;
    assign b32.in_inst_i = inst_d;  assign b32.out_ready_i = out_rdy;
    assign b64.flush_i = flush;  assign b64.in_valid_i = in_vld;  assign b64.in_pc_i = pc_d;
    assign b64.in_inst_i = inst_d;  assign b64.out_ready_i = out_rdy;

    id_pipe #(.XLEN(32), .ADDR_W(32), .ENABLE_M(1'b1)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
    id_pipe #(.XLEN(64), .ADDR_W(32), .ENABLE_M(1'b0)) u64 (.clk(clk), .rst(rst), .bus(b64.slave));

    // Reference decoder: immediates via signed 64-bit arithmetic, fields per opcode family.
    function automatic exp_t model(input int xl, input bit em, input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        longint si;
        logic [6:0] op, f7, up;
        logic [2:0] f3;
        bit ok, use_rd, use_rs1, use_rs2, use_f3;
        e = '0; si = longint'($signed(w));
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        ok = 0; use_rd = 0; use_rs1 = 0; use_rs2 = 0; use_f3 = 0;
        case (op)
            7'h37, 7'h17: begin ok = 1; use_rd = 1; e.imm = (si >>> 12) << 12; end
            7'h6F: begin
                ok = 1; use_rd = 1;
                e.imm = ((si >>> 31) << 20) | (longint'(w[19:12]) << 12) |
                        (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
            end
            7'h67: begin ok = (f3 == 0); use_rd = 1; use_rs1 = 1; use_f3 = 1; e.imm = si >>> 20; end
            7'h63: begin
                ok = (f3 != 2) && (f3 != 3); use_rs1 = 1; use_rs2 = 1; use_f3 = 1;
                e.imm = ((si >>> 31) << 12) | (longint'(w[7]) << 11) |
                        (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
            end
            7'h03: begin
                ok = !(f3 == 7 || (xl == 32 && (f3 == 3 || f3 == 6)));
                use_rd = 1; use_rs1 = 1; use_f3 = 1; e.imm = si >>> 20;
            end
            7'h23: begin
                ok = (xl == 32) ? (f3 <= 2) : (f3 <= 3); use_rs1 = 1; use_rs2 = 1; use_f3 = 1;
                e.imm = ((si >>> 25) << 5) | longint'(w[11:7]);
            end
            7'h13: begin
                use_rd = 1; use_rs1 = 1; use_f3 = 1;
                if (f3 == 1 || f3 == 5) begin
                    up = (xl == 32) ? f7 : {w[31:26], 1'b0};
                    ok = (f3 == 1) ? (up == 0) : (up == 0 || up == 7'h20);
                    e.f7 = up;
                    e.imm = (xl == 32) ? longint'(w[24:20]) : longint'(w[25:20]);
                end else begin
                    ok = 1; e.imm = si >>> 20;
                end
            end
            7'h33: begin
                ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (f7 == 7'h01 && em);
                use_rd = 1; use_rs1 = 1; use_rs2 = 1; use_f3 = 1; e.f7 = f7;
            end
            7'h1B: begin
                ok = (xl == 64); use_rd = 1; use_rs1 = 1; use_f3 = 1;
                if (f3 == 1 || f3 == 5) begin e.f7 = f7; e.imm = longint'(w[24:20]); end
                else e.imm = si >>> 20;
            end
            7'h3B: begin ok = (xl == 64); use_rd = 1; use_rs1 = 1; use_rs2 = 1; use_f3 = 1; e.f7 = f7; end
            7'h73: begin
                if (f3 == 0) ok = (w == 32'h0000_0073 || w == 32'h0010_0073 || w == 32'h3020_0073);
                else if (f3 != 4) begin
                    ok = 1; use_rd = 1; use_f3 = 1; e.csr = w[31:20];
                    if (f3 >= 5) e.imm = longint'(w[19:15]);
                    else use_rs1 = 1;
                end
            end
            default: ok = 0;
        endcase
        if (use_rd)  e.rd  = w[11:7];
        if (use_rs1) e.rs1 = w[19:15];
        if (use_rs2) e.rs2 = w[24:20];
        if (use_f3)  e.f3  = f3;
        e.we = use_rd && (w[11:7] != 0); e.re1 = use_rs1; e.re2 = use_rs2;
        if (xl == 32) e.imm[63:32] = '0;
        if (!ok) begin e = '0; e.err = 1; end
        e.pc = pc; e.opcode = op;
        return e;
    endfunction

    function automatic exp_t pack(input logic [31:0] pc, input logic [6:0] op, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [63:0] imm, input logic [11:0] csr,
                                  input logic we, input logic re1, input logic re2, input logic err);
        exp_t g;
        g.pc = pc; g.opcode = op; g.rd = rd; g.rs1 = rs1; g.rs2 = rs2; g.f3 = f3; g.f7 = f7;
        g.imm = imm; g.csr = csr; g.we = we; g.re1 = re1; g.re2 = re2; g.err = err;
        return g;
    endfunction

    // Monitors: pop and compare on every output transfer.
    always @(negedge clk) begin : mon32
        exp_t g, e;
        if (!rst && b32.out_valid_o && b32.out_ready_i) begin
            g = pack(b32.out_pc_o, b32.out_opcode_o, b32.out_rd_o, b32.out_rs1_o, b32.out_rs2_o,
                     b32.out_funct3_o, b32.out_funct7_o, {32'h0, b32.out_imm_o}, b32.out_csr_addr_o,
                     b32.out_rd_we_o, b32.out_rs1_re_o, b32.out_rs2_re_o, b32.out_err_o);
            checks++;
            if (q32.size() == 0) begin
                errors++; $display("FAIL out32_unexpected got=%h required=none", g);
            end else begin
                e = q32.pop_front();
                if (g !== e) begin errors++; $display("FAIL out32_decode got=%h required=%h", g, e); end
            end
        end
    end

    always @(negedge clk) begin : mon64
        exp_t g, e;
        if (!rst && b64.out_valid_o && b64.out_ready_i) begin
            g = pack(b64.out_pc_o, b64.out_opcode_o, b64.out_rd_o, b64.out_rs1_o, b64.out_rs2_o,
                     b64.out_funct3_o, b64.out_funct7_o, b64.out_imm_o, b64.out_csr_addr_o,
                     b64.out_rd_we_o, b64.out_rs1_re_o, b64.out_rs2_re_o, b64.out_err_o);
            checks++;
            if (q64.size() == 0) begin
                errors++; $display("FAIL out64_unexpected got=%h required=none", g);
            end else begin
                e = q64.pop_front();
                if (g !== e) begin errors++; $display("FAIL out64_decode got=%h required=%h", g, e); end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL %s got=%0h required=%0h", name, got, exp); end
    endtask

    // One clock: drive at posedge+1, record accepted words at negedge, return at next posedge+1.
    task automatic cycle(input logic v, input logic [31:0] w, input logic [31:0] p,
                         input logic fl, input logic ordy, output logic acc);
        in_vld = v; inst_d = w; pc_d = p; flush = fl; out_rdy = ordy;
        @(negedge clk);
        acc = v && b32.in_ready_o;
        if (!fl) begin
            if (v && b32.in_ready_o) q32.push_back(model(32, 1'b1, w, p));
            if (v && b64.in_ready_o) q64.push_back(model(64, 1'b0, w, p));
        end
        @(posedge clk);
        if (fl) begin q32.delete(); q64.delete(); end
        #1;
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 14))
            0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6F;  3: w[6:0] = 7'h67;
            4: w[6:0] = 7'h63;  5: w[6:0] = 7'h03;  6: w[6:0] = 7'h23;  7, 8: w[6:0] = 7'h13;
            9, 10: w[6:0] = 7'h33;  11: w[6:0] = 7'h1B;  12: w[6:0] = 7'h3B;  13: w[6:0] = 7'h73;
            default: ;
        endcase
        if ($urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 2))
                0: w[31:25] = 7'h00;  1: w[31:25] = 7'h20;  default: w[31:25] = 7'h01;
            endcase
            if (w[6:0] == 7'h67) w[14:12] = 3'd0;
        end
        if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 0) begin
            case ($urandom_range(0, 2))
                0: w = 32'h0000_0073;  1: w = 32'h0010_0073;  default: w = 32'h3020_0073;
            endcase
        end
        if ($urandom_range(0, 15) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic acc;
        int   n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", b32.out_valid_o, 0);
        chk("rst_in_ready", b32.in_ready_o, 1);
        chk("rst_imm", b32.out_imm_o, 0);
        chk("rst_err_we", {b32.out_err_o, b32.out_rd_we_o, b64.out_err_o}, 0);
        chk("rst_in_ready64", b64.in_ready_o, 1);
        rst = 1'b0;

        // addi x1,x2,-1 : one-cycle latency
        cycle(1, 32'hFFF1_0093, 32'h100, 0, 1, acc);
        chk("addi_valid", b32.out_valid_o, 1);
        chk("addi_rd_rs1", {b32.out_rd_o, b32.out_rs1_o}, {5'd1, 5'd2});
        chk("addi_imm32", b32.out_imm_o, 32'hFFFF_FFFF);
        chk("addi_imm64", b64.out_imm_o, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_flags", {b32.out_rd_we_o, b32.out_rs1_re_o, b32.out_err_o}, 3'b110);
        cycle(0, 0, 0, 0, 1, acc);

        // backpressure: two accepted, third stalls until the consumer drains
        cycle(1, 32'h0050_0113, 32'h110, 0, 0, acc);  chk("bp_acc1", acc, 1);
        cycle(1, 32'h4020_8233, 32'h114, 0, 0, acc);  chk("bp_acc2", acc, 1);
        chk("bp_in_ready_two", b32.in_ready_o, 0);
        cycle(1, 32'h0000_A183, 32'h118, 0, 0, acc);  chk("bp_stall", acc, 0);
        n = 0;
        do begin cycle(1, 32'h0000_A183, 32'h118, 0, 1, acc); n++; end while (!acc && n < 8);
        chk("bp_acc3", acc, 1);
        repeat (3) cycle(0, 0, 0, 0, 1, acc);
        chk("bp_drained", q32.size(), 0);

        // jal, all-zero word, slli by 32
        cycle(1, 32'h0080_00EF, 32'h200, 0, 1, acc);
        chk("jal_fields", {b32.out_imm_o, b32.out_rd_we_o, b32.out_funct3_o}, {32'd8, 1'b1, 3'd0});
        cycle(1, 32'h0000_0000, 32'h204, 0, 1, acc);
        chk("zero_err", {b32.out_err_o, b32.out_rd_we_o, b32.out_rs1_re_o, b32.out_rs2_re_o}, 4'b1000);
        cycle(1, 32'h0200_9093, 32'h208, 0, 1, acc);
        chk("slli64_legal", {b64.out_err_o, b64.out_imm_o}, {1'b0, 64'd32});
        chk("slli32_illegal", b32.out_err_o, 1);
        cycle(0, 0, 0, 0, 1, acc);

        // flush while full (TWO): nothing held or offered survives
        cycle(1, 32'h0010_0093, 32'h300, 0, 0, acc);
        cycle(1, 32'h0020_0093, 32'h304, 0, 0, acc);
        chk("fl_two", b32.in_ready_o, 0);
        cycle(1, 32'h0030_0093, 32'h308, 1, 0, acc);
        chk("fl_after", {b32.out_valid_o, b32.in_ready_o, b64.out_valid_o}, 3'b010);
        repeat (3) cycle(0, 0, 0, 0, 1, acc);
        // flush in ONE with output taken and a new word offered: output counts, input dropped
        cycle(1, 32'h0040_0093, 32'h310, 0, 0, acc);
        cycle(1, 32'h0050_0093, 32'h314, 1, 1, acc);
        chk("fl_one_after", {b32.out_valid_o, b32.in_ready_o}, 2'b01);
        repeat (2) cycle(0, 0, 0, 0, 1, acc);

        // asynchronous reset between edges
        cycle(1, 32'h0060_0093, 32'h320, 0, 0, acc);
        chk("ar_pre_valid", b32.out_valid_o, 1);
        #2 rst = 1'b1;
        q32.delete(); q64.delete();
        #1;
        chk("ar_valid_drop", {b32.out_valid_o, b64.out_valid_o}, 0);
        chk("ar_in_ready", {b32.in_ready_o, b64.in_ready_o}, 2'b11);
        @(posedge clk); #1 rst = 1'b0;
        cycle(1, 32'hFFF1_0093, 32'h400, 0, 1, acc);
        chk("ar_first_valid", b32.out_valid_o, 1);
        chk("ar_first_pc", b32.out_pc_o, 32'h400);
        cycle(0, 0, 0, 0, 1, acc);

        // randomized stream
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, gen(), $urandom(), $urandom_range(0, 40) == 0,
                  $urandom_range(0, 3) != 0, acc);
        end
        repeat (6) cycle(0, 0, 0, 0, 1, acc);
        chk("end_q32_empty", q32.size(), 0);
        chk("end_q64_empty", q64.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_pipe.md
Name: id_pipe

Overview:
- Registered, parametrised RV32/RV64 instruction-decode stage with a valid/ready handshake and a 2-entry skid buffer. Sits between the if_id_dff output and execute.
- Adds full illegal-instruction detection, register-enable flags, a flush input and XLEN-generic immediates.
- Every decoded field is a registered output; in_ready_o does not depend combinationally on out_ready_i.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; immediates sign-extend to XLEN.
ADDR_W, 32, PC width.
ENABLE_M, 1, 1 = OP funct7 0x01 (M extension) is legal; 0 = it decodes as illegal.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
flush_i  in  1  discard all held entries
in_valid_i  in  1  instruction offered
in_ready_o  out  1  stage can accept
in_pc_i  in  ADDR_W  PC of the offered instruction
in_inst_i  in  32  instruction word
out_valid_o  out  1  decoded entry valid
out_ready_i  in  1  consumer accepts
out_pc_o  out  ADDR_W  PC passthrough
out_opcode_o  out  7  inst[6:0]
out_rd_o/out_rs1_o/out_rs2_o  out  5 each  register addresses; 0 when unused
out_funct3_o  out  3  0 for LUI/AUIPC/JAL
out_funct7_o  out  7  0 when unused
out_imm_o  out  XLEN  sign-extended immediate; zimm zero-extended for CSR*I
out_csr_addr_o  out  12  inst[31:20] for CSR ops, else 0
out_rd_we_o/out_rs1_re_o/out_rs2_re_o  out  1 each  register write/read enables
out_err_o  out  1  illegal instruction

Behaviour:
- Reset (async, active-high): state EMPTY; all outputs 0 except in_ready_o=1.
- Transfer rules: input transfer = in_valid_i & in_ready_o. Output transfer = out_valid_o & out_ready_i.
- Decode: combinational from in_inst_i, captured on input transfer.
- Latency: 1 cycle from input transfer to out_valid_o when the stage is empty.
- States:
  - EMPTY: in_ready=1, out_valid=0. On input transfer -> ONE.
  - ONE: output register full. Input transfer with output transfer -> ONE (output reg reloaded). Input only -> TWO (entry goes to skid). Output only -> EMPTY.
  - TWO: in_ready=0. On output transfer, skid moves to output -> ONE.
- Ordering is strictly FIFO.
- in_ready_o is a registered bit equal to (next state != TWO).
- flush_i (highest priority over everything but rst): next state EMPTY, out_valid_o=0, in_ready_o=1. An input transferred in the flush cycle is discarded. An output transfer in the flush cycle still counts for the consumer.
- Immediates:
  - I/L/JALR: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'h0}, sign-extended above bit 31 when XLEN=64.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Shift-immediate: out_imm_o = shamt, zero-extended; shamt is 5 bits at XLEN=32, 6 bits at XLEN=64.
- Illegal when any of the following holds:
  - Opcode is not one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM, plus OP-IMM-32/OP-32 when XLEN=64.
  - JALR funct3 != 0.
  - BRANCH funct3 is 2 or 3.
  - LOAD funct3 is 3 (XLEN=32 only), 6 (XLEN=32 only), or 7.
  - STORE funct3 > 2 at XLEN=32, or > 3 at XLEN=64.
  - SLLI with upper bits != 0, or SRLI/SRAI with upper bits not 0x00/0x20; upper bits are funct7 at XLEN=32 and inst[31:26] at XLEN=64.
  - OP funct7 not in {0x00, 0x20, 0x01}.
  - OP funct7=0x20 with funct3 not in {0, 5}.
  - OP funct7=0x01 with ENABLE_M=0.
  - SYSTEM funct3=4.
  - SYSTEM funct3=0 and the word is not ECALL 0x00000073, EBREAK 0x00100073 or MRET 0x30200073.
- Illegal entries flow through the pipe normally with out_err_o=1, all enables 0 and all fields 0 except pc and opcode.
- Enables: rd_we=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP and CSR*, and 0 whenever rd=0. rs1_re and rs2_re are set per format.

Test Plan:
- Reset, then in 0xFFF10093 (addi x1,x2,-1) at PC 0x100 -> one cycle later out_valid=1, rd=1, rs1=2, imm=0xFFFFFFFF, rd_we=1, rs1_re=1, err=0.
- out_ready_i=0; offer 3 back-to-back words -> first two accepted, in_ready_o=0 on the cycle after the second. Raise out_ready_i -> all three emerge in order, none lost or duplicated.
- 0x008000EF (jal x1,8) -> imm=8, rd_we=1, funct3=0. 0x00000000 -> err=1, all enables 0.
- XLEN=64: 0x02009093 (slli x1,x1,32) -> legal, imm=32. XLEN=32: same word -> err=1.
- Stage in state TWO with flush_i high for 1 cycle -> out_valid=0 and in_ready=1 next cycle; the entry offered in the flush cycle never appears.
- rst asserted mid-stream, asynchronously between clock edges -> out_valid drops to 0 immediately and in_ready_o=1. After release the first new instruction decodes with 1-cycle latency.
